// File: rtl/pid_cfg_spi_master.sv
// SPI mode-0 master that shifts one NBYTES-byte PID configuration frame out MSB first.
// States: IDLE wait | LEAD cs low before first rise | HIGH sck high | LOW sck low | TRAIL cs hold | GAP cs high, done.
module pid_cfg_spi_master #(
    parameter int NBYTES  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [8*NBYTES-1:0] cfg_data,
    output logic                busy,
    output logic                done,
    output logic                sck,
    output logic                mosi,
    output logic                cs
);
    localparam int N  = 8 * NBYTES;
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BITS_LOAD = BW'(N);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  half_cnt, half_cnt_next;
    logic [BW-1:0]  bit_cnt, bit_cnt_next;
    logic [N-1:0]   shift_reg, shift_next;
    logic           hp_end, active;
    logic           cs_d, sck_d, mosi_d, busy_d, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            half_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            cs        <= 1'b1;
            sck       <= 1'b0;
            mosi      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            half_cnt  <= half_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            cs        <= cs_d;
            sck       <= sck_d;
            mosi      <= mosi_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_next    = state;
        half_cnt_next = half_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        hp_end        = (half_cnt == '0);
        if (state != IDLE)
            half_cnt_next = hp_end ? CNT_LOAD : half_cnt - CW'(1);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next    = LEAD;
                    shift_next    = cfg_data;
                    bit_cnt_next  = BITS_LOAD;
                    half_cnt_next = CNT_LOAD;
                end
            end
            LEAD:  if (hp_end) state_next = HIGH;
            HIGH: begin
                if (hp_end) begin
                    shift_next   = {shift_reg[N-2:0], 1'b0};
                    bit_cnt_next = bit_cnt - BW'(1);
                    state_next   = (bit_cnt == BW'(1)) ? TRAIL : LOW;
                end
            end
            LOW:   if (hp_end) state_next = HIGH;
            TRAIL: if (hp_end) state_next = GAP;
            GAP: begin
                // A start on the last gap cycle chains straight into the next frame.
                if (hp_end) begin
                    if (start) begin
                        state_next   = LEAD;
                        shift_next   = cfg_data;
                        bit_cnt_next = BITS_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_comb begin
        active = (state_next == LEAD) || (state_next == HIGH) ||
                 (state_next == LOW)  || (state_next == TRAIL);
        cs_d   = ~active;
        sck_d  = (state_next == HIGH);
        mosi_d = active & shift_next[N-1];
        busy_d = (state_next != IDLE);
        done_d = (state_next == GAP) && (state != GAP);
    end
endmodule

// File: tb/tb_pid_cfg_spi_master.sv
// Self-checking bench: default frame vectors plus reset, back-to-back and small-parameter sequences.
module tb_pid_cfg_spi_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] cfg0;
    logic [7:0]  cfg1;
    logic        busy0, done0, sck0, mosi0, cs0;
    logic        busy1, done1, sck1, mosi1, cs1;

    int total = 0;
    int bad   = 0;

    int          rises0 = 0;
    logic [31:0] cap0   = '0;
    int          rises1 = 0;
    int          rises1_hi = 0;
    logic [7:0]  cap1   = '0;

    always #5 clk = ~clk;

    pid_cfg_spi_master #(.NBYTES(4), .CLK_DIV(4)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .cfg_data(cfg0),
        .busy(busy0), .done(done0), .sck(sck0), .mosi(mosi0), .cs(cs0)
    );

    pid_cfg_spi_master #(.NBYTES(1), .CLK_DIV(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .cfg_data(cfg1),
        .busy(busy1), .done(done1), .sck(sck1), .mosi(mosi1), .cs(cs1)
    );

    always @(posedge sck0) begin
        cap0   = {cap0[30:0], mosi0};
        rises0 = rises0 + 1;
    end

    always @(posedge sck1) begin
        cap1   = {cap1[6:0], mosi1};
        rises1 = rises1 + 1;
        if (mosi1) rises1_hi = rises1_hi + 1;
    end

    typedef struct {
        logic [31:0] data;
        bit          inject;
        logic [31:0] exp_cap;
        int          exp_done;
        int          exp_busy;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int done_e, busy_e, done_n, cs_after, base;
        done_e = -1; busy_e = -1; done_n = 0; cs_after = 0;
        @(negedge clk);
        cfg0   = v.data;
        start0 = 1'b1;
        base   = rises0;
        @(posedge clk); #1;
        start0 = 1'b0;
        chk("lead_cs", {31'd0, cs0}, 32'd0);
        chk("lead_busy", {31'd0, busy0}, 32'd1);
        chk("lead_mosi", {31'd0, mosi0}, {31'd0, v.data[31]});
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk); #1;
            if (done0) begin
                done_n++;
                if (done_e < 0) done_e = e;
            end
            if (busy_e < 0 && !busy0) busy_e = e;
            if (busy_e >= 0 && !cs0) cs_after++;
            if (e == 3)   chk("pre_rise_sck", {31'd0, sck0}, 32'd0);
            if (e == 4)   chk("first_rise_sck", {31'd0, sck0}, 32'd1);
            if (e == 255) chk("last_high_sck", {31'd0, sck0}, 32'd1);
            if (e == 256) chk("last_fall_sck", {31'd0, sck0}, 32'd0);
            if (v.inject) begin
                if (e == 49 || e == 257) begin
                    start0 = 1'b1;
                    cfg0   = 32'hFFFF_FFFF;
                end else if (e == 50 || e == 258) begin
                    start0 = 1'b0;
                    cfg0   = v.data;
                end
            end
        end
        chk("frame_capture", cap0, v.exp_cap);
        chk("frame_rises", rises0 - base, 32'd32);
        chk("done_edge", done_e, v.exp_done);
        chk("busy_fall_edge", busy_e, v.exp_busy);
        chk("done_pulses", done_n, 32'd1);
        chk("no_second_frame", cs_after, 32'd0);
    endtask

    initial begin
        int quiet_bad, cs_hi, busy_e, done_e, base, mosi_hi, done_seen;

        vecs[0] = '{32'hA5C3_0F81, 1'b0, 32'hA5C3_0F81, 260, 264};
        vecs[1] = '{32'hA5C3_0F81, 1'b1, 32'hA5C3_0F81, 260, 264};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 260, 264};
        vecs[3] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 260, 264};
        vecs[4] = '{32'h8000_0001, 1'b1, 32'h8000_0001, 260, 264};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; cfg0 = '0; cfg1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", {31'd0, cs0}, 32'd1);
        chk("rst_sck", {31'd0, sck0}, 32'd0);
        chk("rst_mosi", {31'd0, mosi0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_cs_small", {31'd0, cs1}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        quiet_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (cs0 !== 1'b1 || sck0 !== 1'b0 || mosi0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0)
                quiet_bad++;
        end
        chk("idle_quiet", quiet_bad, 32'd0);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Back-to-back: start presented on the edge where busy would fall.
        @(negedge clk);
        cfg0 = 32'hA5C3_0F81;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        cs_hi = 0;
        for (int e = 1; e <= 263; e++) begin
            @(posedge clk); #1;
            if (cs0) cs_hi++;
            if (e == 263) begin
                start0 = 1'b1;
                cfg0   = 32'h0000_0001;
            end
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        cfg0   = 32'hFFFF_0000;
        chk("b2b_first_capture", cap0, 32'hA5C3_0F81);
        chk("b2b_cs_gap", cs_hi, 32'd4);
        chk("b2b_busy_held", {31'd0, busy0}, 32'd1);
        chk("b2b_cs_low", {31'd0, cs0}, 32'd0);
        chk("b2b_mosi", {31'd0, mosi0}, 32'd0);
        base = rises0; busy_e = -1;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clk); #1;
            if (busy_e < 0 && !busy0) busy_e = e;
        end
        chk("b2b_second_capture", cap0, 32'h0000_0001);
        chk("b2b_rises", rises0 - base, 32'd32);
        chk("b2b_busy_fall", busy_e, 32'd264);

        // Asynchronous reset while sck is high after the 10th rise.
        @(negedge clk);
        cfg0 = 32'hA5C3_0F81;
        start0 = 1'b1;
        base = rises0;
        done_seen = 0;
        @(posedge clk); #1;
        start0 = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (done0) done_seen++;
            if (rises0 - base >= 10) break;
        end
        chk("rst_mid_tenth_rise", rises0 - base, 32'd10);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid_cs", {31'd0, cs0}, 32'd1);
        chk("rst_mid_sck", {31'd0, sck0}, 32'd0);
        chk("rst_mid_done", {31'd0, done0}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy0}, 32'd0);
        chk("rst_mid_no_done_before", done_seen, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run_frame('{32'h1234_5678, 1'b0, 32'h1234_5678, 260, 264});

        // Small parameter set: one byte, half-period of two clocks.
        @(negedge clk);
        cfg1 = 8'h80;
        start1 = 1'b1;
        base = rises1;
        mosi_hi = 0; done_e = -1; busy_e = -1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cfg1 = 8'hFF;
        if (mosi1) mosi_hi++;
        for (int e = 1; e <= 60; e++) begin
            @(posedge clk); #1;
            if (mosi1) mosi_hi++;
            if (done_e < 0 && done1) done_e = e;
            if (busy_e < 0 && !busy1) busy_e = e;
        end
        chk("small_capture", {24'd0, cap1}, 32'h0000_0080);
        chk("small_rises", rises1 - base, 32'd8);
        chk("small_rises_with_mosi", rises1_hi, 32'd1);
        chk("small_mosi_high_cycles", mosi_hi, 32'd4);
        chk("small_done_edge", done_e, 32'd34);
        chk("small_busy_fall", busy_e, 32'd36);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
